mem_lfsr_bist_ctrl: RTL and testbench

//  Built-in self-test controller for one single-port 1-bit-wide RAM bank (DEPTH x 1, 1-cycle registered read).
//  On start, writes an LFSR pseudo-random bit pattern to every address, re-seeds, reads every address back and compares.

---
 rtl/mem_lfsr_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_lfsr_bist_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lfsr_bist_ctrl.sv
// mem_lfsr_bist_ctrl: built-in self-test controller for one DEPTH x 1 single-port RAM
// with a 1-cycle registered read. On start it writes an LFSR pattern to every address,
// re-seeds, reads every address back and compares, then reports pass/fail, a saturating
// error count and the first failing address. While idle the host owns the RAM port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a test (sampled only when idle)
//   busy              high while writing, reading or draining the compare pipe
//   done              one-cycle pulse at the end of a test
//   pass              last test error-free, held until the next start
//   err_count         number of mismatching addresses (saturating)
//   first_err_addr    address of the first mismatch, 0 if none
//   host_we/addr/data host RAM port, passed through while idle
//   host_q            RAM read data (always mem_q)
//   mem_we/addr/data  RAM port A controls
//   mem_q             RAM port A read data
module mem_lfsr_bist_ctrl #(
  parameter int unsigned        ADDR_W = 11,
  parameter int unsigned        DEPTH  = 2048,
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_data,
  output logic              host_q,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_data,
  input  logic              mem_q
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] SeedEff  = (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StDrain, StDone} state_e;

  state_e              state_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                pipe_vld_q;
  logic                pipe_exp_q;
  logic [ADDR_W-1:0]   pipe_addr_q;

  logic [LFSR_W-1:0]   lfsr_next;
  logic                mismatch;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1 (right-shifting form, taps at bits 0,2,3,5).
  assign lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[LFSR_W-1:1]};

  // mem_q belongs to the address registered into the pipe on the previous edge.
  assign mismatch = pipe_vld_q & (mem_q ^ pipe_exp_q);

  assign host_q = mem_q;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_we   = host_we;
        mem_addr = host_addr;
        mem_data = host_data;
      end
      StWrite: begin
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_data = lfsr_q[0];
      end
      StRead:  mem_addr = addr_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      lfsr_q         <= SeedEff;
      addr_q         <= '0;
      pipe_vld_q     <= 1'b0;
      pipe_exp_q     <= 1'b0;
      pipe_addr_q    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done       <= 1'b0;
      pipe_vld_q <= 1'b0;

      if (mismatch) begin
        // err_count never returns to zero within a run, so zero marks the first miss.
        if (err_count == '0) first_err_addr <= pipe_addr_q;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            lfsr_q         <= SeedEff;
            addr_q         <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state_q        <= StWrite;
          end
        end
        StWrite: begin
          if (addr_q == LastAddr) begin
            addr_q  <= '0;
            lfsr_q  <= SeedEff;
            state_q <= StRead;
          end else begin
            addr_q <= addr_q + 1'b1;
            lfsr_q <= lfsr_next;
          end
        end
        StRead: begin
          pipe_vld_q  <= 1'b1;
          pipe_exp_q  <= lfsr_q[0];
          pipe_addr_q <= addr_q;
          lfsr_q      <= lfsr_next;
          if (addr_q == LastAddr) begin
            addr_q  <= '0;
            state_q <= StDrain;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        StDrain: begin
          // Include the final compare happening this cycle in the verdict.
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_count == '0) && !mismatch;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lfsr_bist_ctrl.sv
// Self-checking bench for mem_lfsr_bist_ctrl: behavioural RAM with injectable
// inverted-read faults, a reference LFSR pattern and a fault-set error model.
module tb_mem_lfsr_bist_ctrl;

  localparam int AW = 11;
  localparam int DP = 2048;
  localparam int SW = 4;
  localparam int SD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          host_data = 1'b0;
  logic          busy, done, pass, host_q, mem_we, mem_data;
  logic          mem_q = 1'b0;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr, mem_addr;

  mem_lfsr_bist_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .host_we(host_we), .host_addr(host_addr), .host_data(host_data), .host_q(host_q),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  // Small build for the DEPTH=16 latency check.
  logic          s_start = 1'b0;
  logic          s_busy, s_done, s_pass, s_host_q, s_mem_we, s_mem_data;
  logic          s_mem_q = 1'b0;
  logic [SW:0]   s_err_count;
  logic [SW-1:0] s_first_err_addr, s_mem_addr;
  logic [SW-1:0] s_host_addr = '0;

  mem_lfsr_bist_ctrl #(.ADDR_W(SW), .DEPTH(SD)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .pass(s_pass), .err_count(s_err_count), .first_err_addr(s_first_err_addr),
    .host_we(1'b0), .host_addr(s_host_addr), .host_data(1'b0), .host_q(s_host_q),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_data(s_mem_data), .mem_q(s_mem_q)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: registered read; a faulty cell returns the inverse of what it holds.
  logic ram [DP];
  logic fault [DP];
  logic wr_log [DP];
  logic ram_s [SD];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr] ^ fault[mem_addr];
    if (mem_we && busy) wr_log[mem_addr] <= mem_data;
    if (s_mem_we) ram_s[s_mem_addr] <= s_mem_data;
    s_mem_q <= ram_s[s_mem_addr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference pattern: bit i is bit 0 of the LFSR after i steps from the seed.
  bit exp_bits [DP];
  function automatic void build_ref();
    int s = 16'hACE1;
    for (int i = 0; i < DP; i++) begin
      int fb;
      exp_bits[i] = bit'(s & 1);
      fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
  endfunction

  function automatic int model_err_count();
    int n = 0;
    for (int i = 0; i < DP; i++) if (fault[i]) n++;
    return (n > (2 ** (AW + 1)) - 1) ? (2 ** (AW + 1)) - 1 : n;
  endfunction

  function automatic int model_first_err();
    for (int i = 0; i < DP; i++) if (fault[i]) return i;
    return 0;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < DP; i++) fault[i] = 1'b0;
  endtask

  // Pulse start, wait for done (bounded) with random host traffic; optionally re-poke
  // start for a few cycles at loop index poke. Returns cycles from the start cycle.
  task automatic run(input int poke, output int lat);
    int n;
    bit seen = 0;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    n = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * DP; i++) begin
      @(negedge clk);
      host_we   = 1'($urandom);
      host_addr = AW'($urandom);
      host_data = 1'($urandom);
      if (poke > 0 && i == poke) start = 1'b1;
      if (poke > 0 && i == poke + 3) start = 1'b0;
      if (done) begin
        lat  = cyc - n;
        seen = 1;
        break;
      end
    end
    host_we = 1'b0;
    start   = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  int lat;
  int n0;
  bit s_seen;

  initial begin
    for (int i = 0; i < DP; i++) begin
      ram[i] = 1'b0;
      fault[i] = 1'b0;
      wr_log[i] = 1'b0;
    end
    for (int i = 0; i < SD; i++) ram_s[i] = 1'b0;
    build_ref();

    // 1: reset state, host passthrough under reset
    for (int k = 0; k < 3; k++) begin
      host_we   = 1'($urandom);
      host_addr = AW'($urandom);
      host_data = 1'($urandom);
      #7;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_first", 32'(first_err_addr), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'(host_we));
      check("rst_mem_addr", 32'(mem_addr), 32'(host_addr));
      check("rst_mem_data", 32'(mem_data), 32'(host_data));
    end
    host_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 6: idle host access, write then read back one cycle later
    for (int k = 0; k < 5; k++) begin
      logic [AW-1:0] a;
      logic d;
      a = (k == 0) ? AW'(7) : AW'($urandom);
      d = (k == 0) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      host_we = 1'b1; host_addr = a; host_data = d;
      @(negedge clk);
      host_we = 1'b0;
      @(negedge clk);
      check("host_rd", 32'(host_q), 32'(d));
    end

    // 2: clean run, latency and written pattern
    run(0, lat);
    check("lat_clean", 32'(lat), 32'(2 * DP + 2));
    check("pass_clean", 32'(pass), 32'd1);
    check("err_clean", 32'(err_count), 32'd0);
    check("first_clean", 32'(first_err_addr), 32'd0);
    for (int i = 0; i < 16; i++) check($sformatf("wr_bit%0d", i), 32'(wr_log[i]), 32'(exp_bits[i]));
    begin
      int bad = 0;
      for (int i = 0; i < DP; i++) if (wr_log[i] != exp_bits[i]) bad++;
      check("wr_all", 32'(bad), 32'd0);
    end

    // 3: faults at 37 and 1000, then results held while idle
    fault[37] = 1'b1;
    fault[1000] = 1'b1;
    run(0, lat);
    check("err_fix", 32'(err_count), 32'(model_err_count()));
    check("first_fix", 32'(first_err_addr), 32'(model_first_err()));
    check("pass_fix", 32'(pass), 32'd0);
    repeat (5) @(negedge clk);
    check("err_held", 32'(err_count), 32'd2);
    check("first_held", 32'(first_err_addr), 32'd37);

    // random fault sets
    for (int r = 0; r < 2; r++) begin
      clear_faults();
      for (int k = 0, nf = $urandom_range(1, 5); k < nf; k++) fault[$urandom_range(0, DP - 1)] = 1'b1;
      run(0, lat);
      check("lat_rand", 32'(lat), 32'(2 * DP + 2));
      check("err_rand", 32'(err_count), 32'(model_err_count()));
      check("first_rand", 32'(first_err_addr), 32'(model_first_err()));
      check("pass_rand", 32'(pass), 32'(model_err_count() == 0));
    end

    // 4: start re-asserted during READ does not restart
    clear_faults();
    run(DP + 100, lat);
    check("lat_poke", 32'(lat), 32'(2 * DP + 2));
    check("pass_poke", 32'(pass), 32'd1);
    repeat (3) @(negedge clk);
    check("idle_after_poke", 32'(busy), 32'd0);

    // 5: reset mid-WRITE at address 500, then a full clean run
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < DP; i++) begin
        @(negedge clk);
        if (busy && mem_we && mem_addr == AW'(500)) begin
          hit = 1;
          break;
        end
      end
      check("reach_addr500", 32'(hit), 32'd1);
    end
    host_we = 1'b1; host_addr = AW'(3); host_data = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_pass", 32'(pass), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd1);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd3);
    host_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(0, lat);
    check("lat_after_rst", 32'(lat), 32'(2 * DP + 2));
    check("pass_after_rst", 32'(pass), 32'd1);

    // DEPTH=16 build: done at N+34
    s_seen = 0;
    @(negedge clk);
    s_start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_done) begin
        s_seen = 1;
        check("lat_small", 32'(cyc - n0), 32'(2 * SD + 2));
        break;
      end
    end
    check("small_done_seen", 32'(s_seen), 32'd1);
    check("small_pass", 32'(s_pass), 32'd1);
    check("small_err", 32'(s_err_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
